// File: rtl/accel_pkg.sv
// accel_pkg: shared types and constants for the global-buffer read path.
//   GB_SIZE / GB_AW : global buffer depth in lines and its address width.
//   reader_state_e  : stream reader FSM states.
//   gb_rd_cmd_t     : strided read command (base line, line count, stride).
//   line_w()        : line width in bits from element width and elements per line.
package accel_pkg;

  localparam int GB_SIZE = 1024;
  localparam int GB_AW   = $clog2(GB_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_e;

  typedef struct packed {
    logic [GB_AW-1:0] base;    // next line address to issue
    logic [GB_AW:0]   count;   // lines still to issue
    logic [GB_AW-1:0] stride;  // address increment per line
  } gb_rd_cmd_t;

  function automatic int line_w(input int data_size, input int if_size);
    return data_size * if_size;
  endfunction

endpackage

// File: rtl/gb_rd_fifo.sv
// gb_rd_fifo: synchronous first-word-fall-through FIFO.
//   clk, nrst     : clock, asynchronous active-low reset
//   push_i/data_i : write strobe and data (ignored when full)
//   pop_i         : consume head entry (ignored when empty)
//   head_o        : head entry, valid whenever empty_o is low
//   empty_o       : no entries stored
//   count_o       : number of stored entries (0..DEPTH)
module gb_rd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every variable gets a default at the top of a combinational block,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // are, and an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/gb_stream_reader.sv
// gb_stream_reader: read-side initiator for the accelerator global buffer.
// Takes a strided read command, issues one line read per cycle on the global
// buffer port while FIFO credit allows, captures returned lines into a FWFT
// FIFO and streams them out with a last marker on the command's final line.
//   clk, nrst                  : clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  : command handshake (ready only when idle)
//   cmd_base_i/count_i/stride_i: first line, number of lines, address step
//   gb_addr_o, gb_rd_en_o      : registered read request to the buffer
//   gb_wr_en_o                 : always 0 (read-only initiator)
//   gb_rd_data_i, gb_valid_i   : returned line, READ_LATENCY after request
//   out_valid_o / out_ready_i  : output stream handshake
//   out_data_o, out_last_o     : stream line and final-line marker
//   done_o                     : one-cycle pulse when the command is complete
//   err_o                      : sticky, set by a return with nothing pending
module gb_stream_reader
  import accel_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int GB_IF_SIZE   = 16,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int LINE_W       = line_w(DATA_SIZE, GB_IF_SIZE)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [GB_AW-1:0]  cmd_base_i,
  input  logic [GB_AW:0]    cmd_count_i,
  input  logic [GB_AW-1:0]  cmd_stride_i,
  output logic [GB_AW-1:0]  gb_addr_o,
  output logic              gb_rd_en_o,
  output logic              gb_wr_en_o,
  input  logic [LINE_W-1:0] gb_rd_data_i,
  input  logic              gb_valid_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [LINE_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int             CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [GB_AW:0] ONE   = (GB_AW + 1)'(1);

  // The buffer cannot be stalled, so the FIFO must absorb every read in flight.
  if ((FIFO_DEPTH < READ_LATENCY + 1) || (READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_cfg_check
    $error("gb_stream_reader: FIFO_DEPTH must be >= READ_LATENCY+1, READ_LATENCY in 1..4");
  end

  reader_state_e    state_q, state_d;
  gb_rd_cmd_t       cmd_q, cmd_d;
  logic [GB_AW:0]   ret_left_q, ret_left_d;      // lines still to come back
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             gb_rd_en_q, gb_rd_en_d;
  logic [GB_AW-1:0] gb_addr_q, gb_addr_d;
  logic             err_q, err_d;

  logic             issue;
  logic             done;
  logic             push;
  logic             push_last;
  logic             spurious;
  logic             credit_ok;
  logic [CNT_W:0]   credit_used;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [LINE_W:0]  fifo_head;

  // A return is only legal while something is outstanding; anything else is
  // dropped so a stray strobe can never corrupt the stream.
  assign push      = gb_valid_i && (outstanding_q != '0);
  assign spurious  = gb_valid_i && (outstanding_q == '0);
  // Returns arrive in issue order, so the last expected return is the last line.
  assign push_last = (ret_left_q == ONE);

  // Outstanding counts from the issue decision, one cycle before the strobe
  // leaves the register, which keeps the credit check conservative.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign credit_ok   = (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    ret_left_d    = ret_left_q;
    outstanding_d = outstanding_q;
    gb_addr_d     = gb_addr_q;
    err_d         = err_q;
    issue         = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          err_d        = 1'b0;
          ret_left_d   = cmd_count_i;
          cmd_d.stride = cmd_stride_i;
          if (cmd_count_i == '0) begin
            cmd_d.base  = cmd_base_i;
            cmd_d.count = '0;
            state_d     = ST_DRAIN;
          end else begin
            // First read goes out straight from acceptance; the FIFO is empty
            // here so credit is guaranteed.
            issue       = 1'b1;
            gb_addr_d   = cmd_base_i;
            cmd_d.base  = cmd_base_i + cmd_stride_i;
            cmd_d.count = cmd_count_i - ONE;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_q.count == '0) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          issue       = 1'b1;
          gb_addr_d   = cmd_q.base;
          cmd_d.base  = cmd_q.base + cmd_q.stride;
          cmd_d.count = cmd_q.count - ONE;
          if (cmd_q.count == ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((outstanding_q == '0) && fifo_empty) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case ({issue, push})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (push)     ret_left_d = ret_left_q - ONE;
    if (spurious) err_d      = 1'b1;
  end

  assign gb_rd_en_d = issue;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      ret_left_q    <= '0;
      outstanding_q <= '0;
      gb_rd_en_q    <= 1'b0;
      gb_addr_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      ret_left_q    <= ret_left_d;
      outstanding_q <= outstanding_d;
      gb_rd_en_q    <= gb_rd_en_d;
      gb_addr_q     <= gb_addr_d;
      err_q         <= err_d;
    end
  end

  gb_rd_fifo #(
    .WIDTH (LINE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (push),
    .data_i  ({push_last, gb_rd_data_i}),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign fifo_pop = out_valid_o && out_ready_i;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign gb_rd_en_o  = gb_rd_en_q;
  assign gb_addr_o   = gb_addr_q;
  assign gb_wr_en_o  = 1'b0;
  assign done_o      = done;
  assign err_o       = err_q;
  assign out_valid_o = !fifo_empty;
  // Gate the head with valid so the stream reads zero when empty, including
  // out of reset, without resetting the FIFO storage.
  assign out_data_o  = fifo_empty ? '0 : fifo_head[LINE_W-1:0];
  assign out_last_o  = !fifo_empty && fifo_head[LINE_W];

endmodule
